// File: rtl/minitb_ahb_slave.sv
// ----------------------------------------------------------------------------
// minitb_ahb_slave
//
// AHB-Lite style memory slave. It holds DEPTH words of dataWidth bits. haddr is
// a word index. The slave supports pipelined transfers, where the next address
// phase is accepted on the same edge that completes the current data phase. It
// can also insert a fixed number of wait states into every OKAY data phase.
//
// Bus handshake (valid/ready view):
//   The address phase is "valid" when hsel=1 and htrans[1]=1 (NONSEQ or SEQ).
//   hready is the slave's "ready". The address phase is accepted on a rising
//   edge where valid and hready are both 1. A data phase completes on the first
//   rising edge with hready=1 after acceptance. hwdata is sampled only on that
//   edge. hrdata is non-zero only during the completing cycle of a read.
//   IDLE, BUSY and hsel=0 are not transfers, and the slave answers them with
//   hready=1, hresp=OKAY.
//
// Optional feature (macro MINITB_AHB_SLAVE_ERR_EN):
//   defined   : an accepted haddr >= DEPTH gets a two-cycle ERROR response.
//               The first cycle is ERR1 (hready=0). The second is the final
//               cycle (hready=1). The write is dropped and hrdata stays 0.
//   undefined : the address wraps (index = haddr mod DEPTH). hresp is tied to
//               OKAY and the ERR1 state does not exist.
//
// Ports:
//   hclk        in   clock, all state updates on the rising edge
//   hresetn     in   asynchronous active-low reset
//   hsel        in   slave select
//   htrans[1:0] in   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   haddr       in   word address (address phase)
//   hwrite      in   1=write, 0=read (address phase)
//   hwdata      in   write data (data phase)
//   hready      out  transfer done / slave ready
//   hresp[1:0]  out  OKAY=00, ERROR=01
//   hrdata      out  read data, valid in the completing cycle of a read
//   dbg_state_o out  current FSM state (IDLE=0, WAIT=1, DATA=2, ERR1=3)
// ----------------------------------------------------------------------------
module minitb_ahb_slave #(
  parameter int addrWidth   = 8,
  parameter int dataWidth   = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic                 hready,
  output logic [1:0]           hresp,
  output logic [dataWidth-1:0] hrdata,
  output logic [1:0]           dbg_state_o
);

  // Index width. DEPTH is a power of two, so "mod DEPTH" is simply the low
  // IW bits of haddr.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Terminal value of the 4-bit wait counter. This is only meaningful when
  // WAIT_STATES > 0, because the WAIT state is never entered otherwise.
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef MINITB_AHB_SLAVE_ERR_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2,
    S_ERR1 = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_e;
`endif

  // State entered by an accepted in-range address phase.
  localparam state_e FIRST_STATE = (WAIT_STATES > 0) ? S_WAIT : S_DATA;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           write_q, write_d;
  logic           err_q, err_d;

  logic           accept;
  logic           addr_err;
  logic           complete;
  logic           unused_ok;

  logic [dataWidth-1:0] mem [DEPTH];

  // Only the low IW bits of haddr select a word, and htrans[0] (SEQ vs
  // NONSEQ) does not change the slave's behaviour.
  assign unused_ok = ^{htrans[0], haddr};

  // hready is a pure decode of the state register. Reset therefore raises it
  // immediately, without waiting for a clock edge.
  assign hready = (state_q == S_IDLE) || (state_q == S_DATA);

  assign accept = hsel && htrans[1] && hready;

  // A data phase completes on any edge where the FSM sits in DATA.
  assign complete = (state_q == S_DATA);

`ifdef MINITB_AHB_SLAVE_ERR_EN
  // Compare in addrWidth+1 bits so DEPTH == 2**addrWidth does not overflow.
  localparam logic [addrWidth:0] DEPTH_EXT = (addrWidth + 1)'(DEPTH);
  assign addr_err = ({1'b0, haddr} >= DEPTH_EXT);
`else
  assign addr_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;

    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d = S_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
`ifdef MINITB_AHB_SLAVE_ERR_EN
      S_ERR1: begin
        state_d = S_DATA;
      end
`endif
      default: ;
    endcase

    // In IDLE and DATA (hready=1), an address phase may be accepted. This is
    // also where a finished data phase hands over to the next pipelined
    // transfer, or drops back to IDLE.
    if (hready) begin
      if (accept) begin
        idx_d   = haddr[IW-1:0];
        write_d = hwrite;
        err_d   = addr_err;
        cnt_d   = 4'd0;
        state_d = FIRST_STATE;
`ifdef MINITB_AHB_SLAVE_ERR_EN
        if (addr_err) begin
          state_d = S_ERR1;
        end
`endif
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        write_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
`ifdef MINITB_AHB_SLAVE_ERR_EN
  // ERROR is driven in both cycles of an error response: ERR1, then the
  // final DATA cycle, which is flagged by err_q.
  assign hresp = ((state_q == S_ERR1) || (complete && err_q)) ? RESP_ERROR : RESP_OKAY;
`else
  assign hresp = RESP_OKAY;
`endif

  // The memory read is combinational. A read whose data phase directly
  // follows a write to the same index therefore sees the value written on
  // the previous edge.
  assign hrdata = (complete && !write_q && !err_q) ? mem[idx_q] : '0;

  assign dbg_state_o = state_q;

  // --------------------------------------------------------------------------
  // Storage. This is not reset. A reset aborts an in-flight write because
  // the state is forced out of DATA before any edge can commit the write.
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (complete && write_q && !err_q) begin
      mem[idx_q] <= hwdata;
    end
  end

endmodule

// File: tb/tb_minitb_ahb_slave.sv
// ----------------------------------------------------------------------------
// tb_minitb_ahb_slave
//
// The bench uses two slave instances that share one bus driver: dut0 has
// WAIT_STATES=0 and dut3 has WAIT_STATES=3. The variable cur selects the
// active instance. The other instance sees hsel=0.
//
// The reference model works at transfer level. Each accepted transfer updates
// an array memory in program order. It then pushes the expected completion
// (read data, response and number of wait cycles) onto a queue. The bus
// driver pops that queue when the data phase completes.
// ----------------------------------------------------------------------------
module tb_minitb_ahb_slave;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  always #5 hclk = ~hclk;
  logic hresetn;

  // ---------------- bus signals ----------------
  logic          hsel;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  int            cur;

  logic          hsel0, hsel3;
  logic          hready0, hready3, hready_m;
  logic [1:0]    hresp0, hresp3, hresp_m;
  logic [DW-1:0] hrdata0, hrdata3, hrdata_m;
  logic [1:0]    dbg0, dbg3;

  assign hsel0    = hsel && (cur == 0);
  assign hsel3    = hsel && (cur == 1);
  assign hready_m = (cur == 1) ? hready3 : hready0;
  assign hresp_m  = (cur == 1) ? hresp3  : hresp0;
  assign hrdata_m = (cur == 1) ? hrdata3 : hrdata0;

  minitb_ahb_slave #(.addrWidth(AW), .dataWidth(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready0), .hresp(hresp0),
    .hrdata(hrdata0), .dbg_state_o(dbg0)
  );

  minitb_ahb_slave #(.addrWidth(AW), .dataWidth(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready3), .hresp(hresp3),
    .hrdata(hrdata3), .dbg_state_o(dbg3)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          sel;
    logic [1:0]    trans;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct packed {
    logic       chk;    // compare hrdata (0 when reading a never-written word)
    logic       err;
    logic [1:0] resp;
    logic [7:0] waits;
  } exp_info_t;

  xfer_t         tx_q[$];
  logic [DW-1:0] exp_q[$];
  exp_info_t     exp_info_q[$];

  logic [DW-1:0] mem_m   [2][DEPTH];
  bit            known_m [2][DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h (dut=%0d t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  // The model applies an accepted transfer in program order and records what
  // its data phase must look like when it completes.
  task automatic model_accept(input xfer_t t);
    exp_info_t ei;
    int idx;
    bit err;
    idx = int'(t.addr) % DEPTH;
`ifdef MINITB_AHB_SLAVE_ERR_EN
    err = (int'(t.addr) >= DEPTH);
`else
    err = 1'b0;
`endif
    ei.err   = err;
    ei.resp  = err ? 2'b01 : 2'b00;
    ei.waits = err ? 8'd1 : ((cur == 1) ? 8'd3 : 8'd0);
    ei.chk   = 1'b1;
    if (err) begin
      exp_q.push_back('0);
    end else if (t.wr) begin
      mem_m[cur][idx]   = t.data;
      known_m[cur][idx] = 1'b1;
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(mem_m[cur][idx]);
      ei.chk = known_m[cur][idx];
    end
    exp_info_q.push_back(ei);
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic sel, input logic [1:0] trans, input int addr,
                      input logic wr, input logic [DW-1:0] data);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.addr = AW'(addr); t.wr = wr; t.data = data;
    tx_q.push_back(t);
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = T_IDLE; haddr = '0; hwrite = 1'b0; hwdata = '0;
  endtask

  // Run the queued address phases as a pipelined master. The task is called
  // and returns 1 time unit after a rising edge.
  task automatic run_bus();
    bit            dp_valid = 0;
    xfer_t         dp = '0;
    xfer_t         t;
    exp_info_t     ei;
    logic [DW-1:0] ed;
    int            waits = 0;
    int            budget = 0;
    while ((tx_q.size() > 0 || dp_valid) && budget < 2000) begin
      budget++;
      if (tx_q.size() > 0) begin
        hsel = tx_q[0].sel; htrans = tx_q[0].trans; haddr = tx_q[0].addr; hwrite = tx_q[0].wr;
      end else begin
        hsel = 1'b0; htrans = T_IDLE; haddr = AW'($urandom); hwrite = 1'($urandom);
      end
      // Correct write data is presented only in the completing cycle.
      hwdata = (dp_valid && dp.wr && hready_m) ? dp.data : $urandom;
      @(negedge hclk);
      if (dp_valid) begin
        ei = exp_info_q[0];
        if (hready_m) begin
          ed = exp_q.pop_front();
          void'(exp_info_q.pop_front());
          check_eq("wait_count", DW'(waits), DW'(ei.waits));
          check_eq("done_resp", DW'(hresp_m), DW'(ei.resp));
          if (ei.chk) check_eq(dp.wr ? "wr_rdata" : "rd_data", hrdata_m, ed);
          dp_valid = 0;
        end else begin
          waits++;
          check_eq("wait_resp", DW'(hresp_m), ei.err ? DW'(1) : DW'(0));
          check_eq("wait_rdata", hrdata_m, '0);
          if (waits > 20) begin
            check_eq("wait_bound", DW'(waits), DW'(ei.waits));
            void'(exp_q.pop_front());
            void'(exp_info_q.pop_front());
            dp_valid = 0;
          end
        end
      end else begin
        check_eq("idle_ready", DW'(hready_m), DW'(1));
        check_eq("idle_resp", DW'(hresp_m), DW'(0));
        check_eq("idle_rdata", hrdata_m, '0);
      end
      if (hready_m && tx_q.size() > 0) begin
        t = tx_q.pop_front();
        if (t.sel && t.trans[1]) begin
          model_accept(t);
          dp = t;
          dp_valid = 1;
          waits = 0;
        end
      end
      @(posedge hclk); #1;
    end
    if (budget >= 2000) check_eq("bus_budget", DW'(budget), DW'(0));
    tx_q.delete();
    exp_q.delete();
    exp_info_q.delete();
    drive_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int addr;
    int r;
    cur = 0;
    drive_idle();
    hresetn = 1'b0;

    // Reset state of both instances.
    repeat (2) @(negedge hclk);
    check_eq("rst_ready0", DW'(hready0), DW'(1));
    check_eq("rst_ready3", DW'(hready3), DW'(1));
    check_eq("rst_resp0", DW'(hresp0), DW'(0));
    check_eq("rst_resp3", DW'(hresp3), DW'(0));
    check_eq("rst_rdata0", hrdata0, '0);
    check_eq("rst_rdata3", hrdata3, '0);
    check_eq("rst_state0", DW'(dbg0), DW'(0));
    check_eq("rst_state3", DW'(dbg3), DW'(0));
    @(posedge hclk); #1;
    hresetn = 1'b1;

    // Zero wait states: a write then a back-to-back read of the same word.
    // The first transfer is accepted on the first edge after reset release.
    cur = 0;
    push(1, T_NONSEQ, 'h05, 1, 32'hDEAD_BEEF);
    push(1, T_NONSEQ, 'h05, 0, '0);
    run_bus();

    // Four pipelined writes followed by four reads.
    for (int i = 0; i < 4; i++) push(1, (i == 0) ? T_NONSEQ : T_SEQ, i, 1, DW'(i + 1));
    for (int i = 0; i < 4; i++) push(1, (i == 0) ? T_NONSEQ : T_SEQ, i, 0, '0);
    run_bus();

    // Three wait states.
    cur = 1;
    push(1, T_NONSEQ, 'h05, 1, 32'hDEAD_BEEF);
    push(1, T_NONSEQ, 'h05, 0, '0);
    push(1, T_NONSEQ, 'h00, 1, 32'h0000_00AA);
    run_bus();

    // Out-of-range address on both instances, then read word 0.
    for (int d = 0; d < 2; d++) begin
      cur = d;
      push(1, T_NONSEQ, 'h40, 1, 32'hC0DE_0040);
      push(1, T_NONSEQ, 'h00, 0, '0);
      push(1, T_NONSEQ, 'h40, 0, '0);
      run_bus();
    end

    // BUSY and hsel=0 with a valid address must not touch memory.
    cur = 0;
    push(1, T_BUSY, 'h05, 1, 32'h1234_5678);
    push(0, T_NONSEQ, 'h05, 1, 32'h8765_4321);
    push(1, T_IDLE, 'h05, 1, 32'h5555_5555);
    push(1, T_NONSEQ, 'h05, 0, '0);
    run_bus();

    // Reset while a write to 0x07 is in its wait states.
    cur = 1;
    push(1, T_NONSEQ, 'h07, 1, 32'h1111_1111);
    run_bus();
    hsel = 1'b1; htrans = T_NONSEQ; haddr = 'h07; hwrite = 1'b1; hwdata = 32'h2222_2222;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = T_IDLE;
    check_eq("abort_pre_ready", DW'(hready_m), DW'(0));
    @(negedge hclk);
    hresetn = 1'b0;
    #1;
    check_eq("abort_ready", DW'(hready_m), DW'(1));
    check_eq("abort_resp", DW'(hresp_m), DW'(0));
    check_eq("abort_rdata", hrdata_m, '0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    push(1, T_NONSEQ, 'h07, 0, '0);
    run_bus();

    // Randomized mixed traffic.
    for (int s = 0; s < 30; s++) begin
      cur = $urandom_range(0, 1);
      for (int k = 0; k < 10; k++) begin
        r = $urandom_range(0, 9);
        addr = $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 64 : 0);
        if (r < 4)       push(1, 2'($urandom_range(2, 3)), addr, 1, $urandom);
        else if (r < 7)  push(1, 2'($urandom_range(2, 3)), addr, 0, '0);
        else if (r == 7) push(1, T_IDLE, addr, 1, $urandom);
        else if (r == 8) push(1, T_BUSY, addr, 1, $urandom);
        else             push(0, 2'($urandom_range(2, 3)), addr, 1, $urandom);
      end
      run_bus();
    end

    repeat (3) @(posedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
